map_arbiter: RTL and testbench
==============================

// Module: map_arbiter
// PURPOSE
//  Shares the game map RAM among N object controllers (digger=0, bullet=1, gobs=2..N-1).
//  Grants one pending move/rotate request at a time, round-robin, and reads the target cell.
//  Answers with a 1-cycle ACK/NACK, updates the map, and writes back exist=00 to destroyed objects.
// PARAMETERS
//  N        4    number of requesters (>=3)
//  SW       16   status width {exist[15:14],x[13:10],y[9:6],dir[5:4],type[3:0]}
//  HMAX     15   largest legal x
//  VMAX     10   largest legal y
// PORTS
//  clk          in   1     clock
//  rst          in   1     synchronous, active-high reset
//  req          in   N     per-requester request, held until ack|nack
//  req_type     in   2*N   slice k: 00 move, 01 rotate
//  req_content  in   8*N   move: {x[7:4],y[3:0]} target; rotate: {6'b0,dir}
//  status       in   SW*N  current status of each requester
//  ack          out  N     one-hot 1-cycle accept pulse
//  nack         out  N     one-hot 1-cycle reject pulse
//  wr           out  N     1-cycle status write strobes (may be multi-hot)
//  data_out     out  SW*N  slice k = {2'b00,status_k[13:0]} while wr[k]
//  map_addr     out  8     {x,y} cell address
//  map_rdata    in   4     cell type, valid 1 cycle after map_addr
//  map_we       out  1     map write strobe
//  map_wdata    out  4     type written
//  busy         out  1     high in any state other than IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE, rr pointer=0; ack, nack, wr, map_we and busy=0; map_addr, map_wdata and data_out=0.
//  IDLE: pick the first set req[k] at or after the pointer; latch k, type, content and status_k.
//   Set pointer=k+1 mod N.
//  Move: IDLE->READ->DECIDE->CLR->SET->RESP->IDLE; ack/nack is 5 clk after the IDLE sample.
//  Rotate: IDLE->SET->RESP, always ACK. SET writes type 3/4/1/2 (UP/DOWN/LEFT/RIGHT) at (x,y) only when k=0.
//  Immediate NACK (IDLE->RESP) when any of these holds:
//   - status_k exist==00;
//   - target x>HMAX or y>VMAX, which includes 4-bit wrap from 0 to 15;
//   - the target is not orthogonally adjacent.
//  DECIDE rules on map_rdata T for move:
//   digger: T in {0,9,15}: ACK. T in 6..8 (gob): NACK, digger killed. Otherwise NACK.
//   bullet: T=0: ACK. T in 6..8: bullet and the matching gob are killed, bullet gets NACK.
//    Any other T: NACK, bullet killed.
//   gob: T=0: ACK. T in 1..4: ACK, digger killed. Otherwise NACK.
//  Matching gob: the lowest index j>=2 with exist!=00 and status_j x,y == target. If none, only the bullet dies.
//  CLR: map_we with wdata=0 at the old (x,y) when the requester moved or died. Otherwise no write.
//  SET: map_we at the target when:
//   - ACK: requester type;
//   - bullet hit a gob: 0.
//   Otherwise no write.
//  RESP: pulse ack[k] or nack[k] for one cycle, plus wr[] to every killed object, in the same cycle.
//  The requester drops req the cycle after RESP, so IDLE never regrants the same request.
//  req deasserted before RESP: the transaction still completes, and the pulse is ignored.
//  Reset mid-transaction: abort to IDLE. No pulses. A map write already issued stays.
// CONFIGURATION
//  ARB_SCORE_EN defined: adds output score[15:0], reset 0.
//   +25 on digger ACK into diamond (T=9); +250 per gob killed; saturates at 16'hFFFF.
//   Updated in the RESP cycle.
//  ARB_SCORE_EN undefined: there is no score port and no counter.
// TESTING
//  1. Digger at (3,3), dir LEFT, req move to (2,3); map_rdata=0. Required, in order:
//     CLR writes 0 to (3,3); SET writes 1 to (2,3); ack[0] 5 cycles after the request.
//  2. req[0] and req[2] set together with pointer 0. Required: grant 0 and then 2, and the pointer ends at 3.
//  3. Bullet at (5,5) moves to (6,5), map=7, gob2 sits at (6,5). Required: in the same cycle, nack[1] and wr[1]|wr[2].
//     Both writes have exist=00. (5,5) and (6,5) are cleared. With ARB_SCORE_EN, score=250.
//  4. Digger at x=0 asks for x=15. Required: nack[0] 1 cycle after sampling, and no map_we.
//  5. Gob3 moves onto a digger cell (T=2). Required: ack[3], wr[0] with exist=00, and the cell is rewritten with gob3's type.
//  6. rst in the DECIDE state. Required: the next cycle is IDLE, all outputs are 0, and there is no ack/nack.

Source files
------------

// File: rtl/map_arbiter.sv
// map_arbiter: round-robin arbiter that gives object controllers exclusive access to the map RAM.
// Define ARB_SCORE_EN to add the saturating score output.
module map_arbiter #(
  parameter int N    = 4,
  parameter int SW   = 16,
  parameter int HMAX = 15,
  parameter int VMAX = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [2*N-1:0]  req_type,
  input  logic [8*N-1:0]  req_content,
  input  logic [SW*N-1:0] status,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    nack,
  output logic [N-1:0]    wr,
  output logic [SW*N-1:0] data_out,
  output logic [7:0]      map_addr,
  input  logic [3:0]      map_rdata,
  output logic            map_we,
  output logic [3:0]      map_wdata,
  output logic            busy
`ifdef ARB_SCORE_EN
  ,
  output logic [15:0]     score
`endif
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, READ, DECIDE, CLR, SET, RESP} state_t;
  state_t st_q, st_d;

  logic [N-1:0][1:0]    rtype;
  logic [N-1:0][7:0]    rcont;
  logic [N-1:0][SW-1:0] stat_a, dout_a;
  assign rtype    = req_type;
  assign rcont    = req_content;
  assign stat_a   = status;
  assign data_out = dout_a;

  logic [PW-1:0] rr_q, k_q;
  logic [SW-1:0] stat_q;
  logic [7:0]    tgt_q;
  logic [N-1:0]  kill_q;
  logic [3:0]    setd_q;
  logic          acc_q, clr_q, setw_q, diam_q, gobk_q;

  // Round-robin search: lowest offset from the pointer wins.
  logic          gnt_vld;
  logic [PW-1:0] gnt_k, idx;
  always_comb begin
    gnt_vld = 1'b0;
    gnt_k   = '0;
    idx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = PW'((int'(rr_q) + i) % N);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_k   = idx;
      end
    end
  end

  logic [SW-1:0] g_stat;
  logic [7:0]    g_cont;
  logic          g_rot, g_adj, g_bad;
  logic [3:0]    cx, cy, tx, ty, dx, dy, rot_t;
  always_comb begin
    g_stat = stat_a[gnt_k];
    g_cont = rcont[gnt_k];
    g_rot  = (rtype[gnt_k] == 2'b01);
    cx     = g_stat[13:10];
    cy     = g_stat[9:6];
    tx     = g_cont[7:4];
    ty     = g_cont[3:0];
    dx     = (tx >= cx) ? tx - cx : cx - tx;
    dy     = (ty >= cy) ? ty - cy : cy - ty;
    g_adj  = (({1'b0, dx} + {1'b0, dy}) == 5'd1);
    g_bad  = (g_stat[15:14] == 2'b00) ||
             (!g_rot && ((int'(tx) > HMAX) || (int'(ty) > VMAX) || !g_adj));
    case (g_cont[1:0])
      2'd0:    rot_t = 4'd3;
      2'd1:    rot_t = 4'd4;
      2'd2:    rot_t = 4'd1;
      default: rot_t = 4'd2;
    endcase
  end

  // Bullet victim: lowest live gob standing on the target cell.
  logic          match_vld;
  logic [PW-1:0] match_j;
  always_comb begin
    match_vld = 1'b0;
    match_j   = '0;
    for (int j = N - 1; j >= 2; j--) begin
      if (stat_a[j][15:14] != 2'b00 && stat_a[j][13:6] == tgt_q) begin
        match_vld = 1'b1;
        match_j   = PW'(j);
      end
    end
  end

  logic          t_gob, t_dig, d_acc, d_die, d_kdig, d_hit;
  logic [N-1:0]  kill_d;
  always_comb begin
    t_gob  = (map_rdata >= 4'd6) && (map_rdata <= 4'd8);
    t_dig  = (map_rdata >= 4'd1) && (map_rdata <= 4'd4);
    d_acc  = 1'b0;
    d_die  = 1'b0;
    d_kdig = 1'b0;
    d_hit  = 1'b0;
    kill_d = '0;
    if (k_q == PW'(0)) begin
      d_acc = (map_rdata == 4'd0) || (map_rdata == 4'd9) || (map_rdata == 4'd15);
      d_die = t_gob;
    end else if (k_q == PW'(1)) begin
      d_acc = (map_rdata == 4'd0);
      d_hit = t_gob;
      d_die = !d_acc;
    end else begin
      d_acc  = (map_rdata == 4'd0) || t_dig;
      d_kdig = t_dig;
    end
    if (d_die)               kill_d[k_q]     = 1'b1;
    if (d_kdig)              kill_d[0]       = 1'b1;
    if (d_hit && match_vld)  kill_d[match_j] = 1'b1;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:   if (gnt_vld) st_d = g_bad ? RESP : (g_rot ? SET : READ);
      READ:   st_d = DECIDE;
      DECIDE: st_d = CLR;
      CLR:    st_d = SET;
      SET:    st_d = RESP;
      RESP:   st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      rr_q   <= '0;
      k_q    <= '0;
      stat_q <= '0;
      tgt_q  <= '0;
      kill_q <= '0;
      setd_q <= '0;
      acc_q  <= 1'b0;
      clr_q  <= 1'b0;
      setw_q <= 1'b0;
      diam_q <= 1'b0;
      gobk_q <= 1'b0;
    end else begin
      st_q <= st_d;
      case (st_q)
        IDLE: if (gnt_vld) begin
          k_q    <= gnt_k;
          rr_q   <= (int'(gnt_k) == N - 1) ? '0 : gnt_k + PW'(1);
          stat_q <= g_stat;
          tgt_q  <= g_rot ? g_stat[13:6] : g_cont;
          acc_q  <= g_rot && !g_bad;
          kill_q <= '0;
          clr_q  <= 1'b0;
          setw_q <= g_rot && !g_bad && (gnt_k == PW'(0));
          setd_q <= rot_t;
          diam_q <= 1'b0;
          gobk_q <= 1'b0;
        end
        DECIDE: begin
          acc_q  <= d_acc;
          kill_q <= kill_d;
          clr_q  <= d_acc || d_die;
          setw_q <= d_acc || d_hit;
          setd_q <= d_acc ? stat_q[3:0] : 4'd0;
          diam_q <= (k_q == PW'(0)) && (map_rdata == 4'd9);
          gobk_q <= d_hit && match_vld;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack       = '0;
    nack      = '0;
    wr        = '0;
    map_addr  = '0;
    map_we    = 1'b0;
    map_wdata = '0;
    busy      = (st_q != IDLE);
    case (st_q)
      READ: map_addr = tgt_q;
      CLR: begin
        map_addr = stat_q[13:6];
        map_we   = clr_q;
      end
      SET: begin
        map_addr  = tgt_q;
        map_we    = setw_q;
        map_wdata = setd_q;
      end
      RESP: begin
        ack[k_q]  = acc_q;
        nack[k_q] = !acc_q;
        wr        = kill_q;
      end
      default: ;
    endcase
  end

  // Killed objects get their status back with exist cleared.
  always_comb begin
    dout_a = '0;
    for (int j = 0; j < N; j++)
      if (wr[j]) dout_a[j] = {2'b00, stat_a[j][SW-3:0]};
  end

  logic unused_bits;
  assign unused_bits = ^{stat_q[15:14], stat_q[5:4]};

`ifdef ARB_SCORE_EN
  logic [15:0] score_q;
  logic [16:0] score_sum;
  assign score_sum = {1'b0, score_q} + (diam_q ? 17'd25 : 17'd0) + (gobk_q ? 17'd250 : 17'd0);
  always_ff @(posedge clk) begin
    if (rst)                score_q <= '0;
    else if (st_q == RESP)  score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end
  assign score = score_q;
`else
  logic unused_score;
  assign unused_score = diam_q ^ gobk_q;
`endif

endmodule

// File: tb/tb_map_arbiter.sv
// Scoreboard bench for map_arbiter: a rule-level model predicts responses and map writes,
// a forked monitor pops and compares them whenever the DUT presents a write or a pulse.
`timescale 1ns/1ps
module tb_map_arbiter;
  localparam int N  = 4;
  localparam int SW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [2*N-1:0]  req_type;
  logic [8*N-1:0]  req_content;
  logic [SW*N-1:0] status;
  logic [N-1:0]    ack, nack, wr;
  logic [SW*N-1:0] data_out;
  logic [7:0]      map_addr;
  logic [3:0]      map_rdata = '0;
  logic            map_we;
  logic [3:0]      map_wdata;
  logic            busy;
`ifdef ARB_SCORE_EN
  logic [15:0]     score;
`endif

  map_arbiter #(.N(N), .SW(SW), .HMAX(15), .VMAX(10)) dut (
    .clk(clk), .rst(rst), .req(req), .req_type(req_type), .req_content(req_content),
    .status(status), .ack(ack), .nack(nack), .wr(wr), .data_out(data_out),
    .map_addr(map_addr), .map_rdata(map_rdata), .map_we(map_we), .map_wdata(map_wdata),
    .busy(busy)
`ifdef ARB_SCORE_EN
    , .score(score)
`endif
  );

  always #5 clk = ~clk;

  logic [1:0]  rt [N];
  logic [7:0]  rc [N];
  logic [15:0] st [N];
  always_comb begin
    req_type    = '0;
    req_content = '0;
    status      = '0;
    for (int j = 0; j < N; j++) begin
      req_type[2*j +: 2]     = rt[j];
      req_content[8*j +: 8]  = rc[j];
      status[SW*j +: SW]     = st[j];
    end
  end

  // Map RAM: one-cycle read latency, plus a bench-side preload port.
  logic [3:0] mem [256] = '{default: 4'd0};
  logic       ld_en = 1'b0;
  logic [7:0] ld_a  = '0;
  logic [3:0] ld_d  = '0;
  always @(posedge clk) begin
    map_rdata <= mem[map_addr];
    if (map_we)     mem[map_addr] <= map_wdata;
    else if (ld_en) mem[ld_a] <= ld_d;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int k; bit acc; logic [N-1:0] wr; int lat; } resp_t;
  resp_t      rq[$];
  logic [11:0] wq[$];
  logic [3:0] mm [256];
  int mptr, mscore, iss_cyc, checks, errors;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h, required nothing (t=%0t)", nm, act, $time);
  endtask

  task automatic monitor();
    resp_t e;
    logic [11:0] w;
    logic [N-1:0] oh;
    logic [15:0] dexp;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (map_we) begin
          if (wq.size() == 0) flag("unexpected_map_we", 64'({map_addr, map_wdata}));
          else begin
            w = wq.pop_front();
            chk("map_write", 64'({map_addr, map_wdata}), 64'(w));
          end
        end
        if (|ack || |nack) begin
          if (rq.size() == 0) flag("unexpected_response", 64'({ack, nack}));
          else begin
            e = rq.pop_front();
            oh = '0;
            oh[e.k] = 1'b1;
            chk("ack", 64'(ack), 64'(e.acc ? oh : '0));
            chk("nack", 64'(nack), 64'(e.acc ? '0 : oh));
            chk("wr", 64'(wr), 64'(e.wr));
            for (int j = 0; j < N; j++) begin
              dexp = e.wr[j] ? {2'b00, st[j][13:0]} : 16'h0;
              chk("data_out", 64'(data_out[SW*j +: SW]), 64'(dexp));
            end
            if (e.lat >= 0) chk("latency", 64'(cyc - iss_cyc), 64'(e.lat));
          end
        end else if (|wr) flag("wr_without_response", 64'(wr));
      end
    end
  endtask

  task automatic mwrite(input logic [3:0] x, input logic [3:0] y, input logic [3:0] d);
    wq.push_back({x, y, d});
    mm[{x, y}] = d;
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: outcome of one granted request from the game rules and the model map.
  task automatic predict(input int k, input bit lat_en);
    resp_t e;
    logic [3:0] cx, cy, tx, ty, typ, t;
    int lat, gj;
    bit acc, die, kdig, hit;
    logic [3:0] rotmap [4];
    rotmap = '{4'd3, 4'd4, 4'd1, 4'd2};
    cx = st[k][13:10]; cy = st[k][9:6]; typ = st[k][3:0];
    tx = rc[k][7:4];   ty = rc[k][3:0];
    acc = 0; die = 0; kdig = 0; hit = 0; gj = -1;
    e.wr = '0;
    if (st[k][15:14] == 2'b00) lat = 1;
    else if (rt[k] == 2'b01) begin
      acc = 1; lat = 2;
      if (k == 0) mwrite(cx, cy, rotmap[rc[k][1:0]]);
    end else if (int'(ty) > 10 ||
                 iabs(int'(tx) - int'(cx)) + iabs(int'(ty) - int'(cy)) != 1) lat = 1;
    else begin
      lat = 5;
      t = mm[{tx, ty}];
      if (k == 0) begin
        acc = (t == 0 || t == 9 || t == 15);
        die = (t >= 6 && t <= 8);
      end else if (k == 1) begin
        acc = (t == 0);
        hit = (t >= 6 && t <= 8);
        die = !acc;
        if (hit)
          for (int j = 2; j < N; j++)
            if (gj < 0 && st[j][15:14] != 2'b00 && st[j][13:10] == tx && st[j][9:6] == ty) gj = j;
      end else begin
        kdig = (t >= 1 && t <= 4);
        acc  = (t == 0) || kdig;
      end
      if (acc || die) mwrite(cx, cy, 4'd0);
      if (acc)        mwrite(tx, ty, typ);
      else if (hit)   mwrite(tx, ty, 4'd0);
      if (die)     e.wr[k]  = 1'b1;
      if (kdig)    e.wr[0]  = 1'b1;
      if (gj >= 0) e.wr[gj] = 1'b1;
      if (k == 0 && acc && t == 9) mscore += 25;
      if (gj >= 0) mscore += 250;
      if (mscore > 65535) mscore = 65535;
    end
    e.k = k; e.acc = acc; e.lat = lat_en ? lat : -1;
    rq.push_back(e);
  endtask

  task automatic run(input logic [N-1:0] mask);
    logic [N-1:0] pend;
    int t, k, n;
    n = $countones(mask);
    for (int c = 0; c < N; c++) begin
      k = (mptr + c) % N;
      if (mask[k]) predict(k, n == 1);
    end
    for (int c = 0; c < N; c++) if (mask[(mptr + N - 1 - c) % N]) begin
      mptr = ((mptr + N - 1 - c) % N + 1) % N;
      break;
    end
    req = req | mask;
    iss_cyc = cyc;
    pend = mask;
    t = 0;
    while (pend != 0 && t < 100) begin
      @(negedge clk);
      t++;
      pend = pend & ~(ack | nack);
      req  = req & ~(ack | nack);
    end
    if (pend != 0) begin
      flag("response_timeout", 64'(pend));
      req = '0;
    end
    @(negedge clk);
`ifdef ARB_SCORE_EN
    chk("score", 64'(score), 64'(mscore));
`endif
  endtask

  task automatic poke(input logic [3:0] x, input logic [3:0] y, input logic [3:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_a = {x, y}; ld_d = d;
    mm[{x, y}] = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic obj(input int j, input logic [1:0] ex, input logic [3:0] x, input logic [3:0] y,
                     input logic [1:0] dir, input logic [3:0] typ);
    st[j] = {ex, x, y, dir, typ};
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_busy"}, 64'(busy), 0);
    chk({nm, "_ack"}, 64'(ack), 0);
    chk({nm, "_nack"}, 64'(nack), 0);
    chk({nm, "_wr"}, 64'(wr), 0);
    chk({nm, "_map_we"}, 64'(map_we), 0);
    chk({nm, "_map_addr"}, 64'(map_addr), 0);
    chk({nm, "_map_wdata"}, 64'(map_wdata), 0);
    chk({nm, "_data_out"}, 64'(data_out), 0);
`ifdef ARB_SCORE_EN
    chk({nm, "_score"}, 64'(score), 0);
`endif
  endtask

  initial begin
    logic [3:0] x, y, tx, ty;
    int k, d;
    checks = 0; errors = 0; mptr = 0; mscore = 0; iss_cyc = 0;
    for (int a = 0; a < 256; a++) mm[a] = 4'd0;
    for (int j = 0; j < N; j++) begin rt[j] = 2'b00; rc[j] = '0; st[j] = '0; end
    req = '0;
    rst = 1'b1;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Two simultaneous requests from pointer 0, then 0 and 3 to observe pointer=3.
    obj(0, 2'b01, 4'd2, 4'd3, 2'd2, 4'd1); rc[0] = {4'd2, 4'd4};
    obj(2, 2'b01, 4'd8, 4'd8, 2'd0, 4'd6); rc[2] = {4'd8, 4'd7};
    obj(1, 2'b01, 4'd12, 4'd1, 2'd0, 4'd5);
    obj(3, 2'b01, 4'd14, 4'd9, 2'd0, 4'd7); rc[3] = {4'd14, 4'd10};
    run(4'b0101);
    rc[0] = {4'd3, 4'd3};
    run(4'b1001);

    // Digger (3,3) LEFT to (2,3) on an empty cell.
    obj(0, 2'b01, 4'd3, 4'd3, 2'd2, 4'd1); rc[0] = {4'd2, 4'd3};
    poke(4'd3, 4'd3, 4'd1); poke(4'd2, 4'd3, 4'd0);
    run(4'b0001);

    // Bullet (5,5)->(6,5) hits gob2.
    obj(1, 2'b01, 4'd5, 4'd5, 2'd3, 4'd5); rc[1] = {4'd6, 4'd5};
    obj(2, 2'b01, 4'd6, 4'd5, 2'd0, 4'd7);
    obj(3, 2'b01, 4'd9, 4'd4, 2'd0, 4'd8);
    poke(4'd6, 4'd5, 4'd7);
    run(4'b0010);

    // Digger at x=0 asks for x=15.
    obj(0, 2'b01, 4'd0, 4'd3, 2'd2, 4'd1); rc[0] = {4'd15, 4'd3};
    run(4'b0001);

    // Gob3 moves onto the digger.
    obj(0, 2'b01, 4'd9, 4'd5, 2'd0, 4'd2); rc[3] = {4'd9, 4'd5};
    poke(4'd9, 4'd5, 4'd2);
    run(4'b1000);

    // Digger rotate writes its direction type; bullet rotate does not touch the map.
    rt[0] = 2'b01; rc[0] = {6'b0, 2'd0};
    run(4'b0001);
    rt[1] = 2'b01; rc[1] = {6'b0, 2'd3};
    run(4'b0010);
    rt[0] = 2'b00; rt[1] = 2'b00;

    // Reset while in DECIDE: abort, no response.
    obj(0, 2'b01, 4'd4, 4'd4, 2'd0, 4'd1); rc[0] = {4'd4, 4'd5};
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", 64'(busy), 1);
    rst = 1'b1; req = '0;
    @(negedge clk);
    check_idle_outputs("abort");
    rst = 1'b0; mptr = 0; mscore = 0;
    repeat (8) @(negedge clk);

    // Randomized transactions.
    for (int it = 0; it < 120; it++) begin
      for (int j = 0; j < N; j++) begin
        x = 4'($urandom_range(0, 15));
        y = 4'($urandom_range(0, ($urandom_range(0, 7) == 0) ? 15 : 10));
        obj(j, ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3)), x, y,
            2'($urandom_range(0, 3)),
            (j == 0) ? 4'($urandom_range(1, 4)) : (j == 1) ? 4'd5 : 4'($urandom_range(6, 8)));
      end
      k = $urandom_range(0, N - 1);
      x = st[k][13:10]; y = st[k][9:6];
      d = $urandom_range(0, 5);
      tx = (d == 0) ? x - 4'd1 : (d == 1) ? x + 4'd1 : x;
      ty = (d == 2) ? y - 4'd1 : (d == 3) ? y + 4'd1 : y;
      if (d >= 4) begin tx = 4'($urandom_range(0, 15)); ty = 4'($urandom_range(0, 15)); end
      rt[k] = ($urandom_range(0, 4) == 0) ? 2'b01 : 2'b00;
      rc[k] = (rt[k] == 2'b01) ? {6'b0, 2'($urandom_range(0, 3))} : {tx, ty};
      if (k == 1 && $urandom_range(0, 1) == 1)
        st[$urandom_range(2, N - 1)][13:6] = {tx, ty};
      poke(tx, ty, ($urandom_range(0, 2) == 0) ? 4'($urandom_range(6, 8)) : 4'($urandom_range(0, 15)));
      run(4'(1 << k));
      rt[k] = 2'b00;
    end

    repeat (4) @(negedge clk);
    chk("resp_queue_empty", 64'(rq.size()), 0);
    chk("write_queue_empty", 64'(wq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
